// File: rtl/rob_mem_responder.sv
// rtl/rob_mem_responder.sv - ROB commit-port responder serialising stores and IO loads onto a byte-wide RAM/IO bus
module rob_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = 32'h30000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_rob_ce,
  input  logic                  in_rob_load_ce,
  input  logic [5:0]            in_rob_size,
  input  logic [ADDR_WIDTH-1:0] in_rob_addr,
  input  logic [DATA_WIDTH-1:0] in_rob_data,
  output logic                  out_rob_ce,
  output logic [DATA_WIDTH-1:0] out_rob_data,
  output logic                  out_busy,
  output logic [ADDR_WIDTH-1:0] out_ram_a,
  output logic [7:0]            out_ram_dout,
  output logic                  out_ram_wr,
  input  logic [7:0]            in_ram_din,
  input  logic                  io_buffer_full
);

  // WRITE issues store bytes, READ issues addresses and collects bytes,
  // DONE is the cycle holding the last byte on the bus; the completion
  // pulse is registered on the way back to IDLE so IDLE can accept the
  // next request in the same cycle the pulse is visible.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              size;
  logic [DATA_WIDTH-1:0]   data;
  logic [2:0]              cnt;
  logic [2:0]              rcnt;
  logic                    is_load;
  logic                    cap;
  logic                    ram_wr_q;

  logic [2:0]              cnt_inc;
  logic [2:0]              rcnt_inc;
  logic                    wr_stall;
  logic                    rd_issue;
  logic [2:0]              rd_cnt_nxt;
  logic [2:0]              rd_rcnt_nxt;
  logic                    rd_last;
  logic [DATA_WIDTH-1:0]   data_merged;

  function automatic logic [2:0] decode_size(input logic [5:0] s);
    case (s)
      6'd1:    return 3'd1;
      6'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // IO space is every address whose IO_BASE bits are all set
  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return (a & IO_BASE) == IO_BASE;
  endfunction

  function automatic logic [7:0] byte_of(input logic [DATA_WIDTH-1:0] d, input logic [2:0] i);
    return 8'(d >> {i, 3'b000});
  endfunction

  // write strobe is frozen together with the rest of the block while rdy is low
  assign out_ram_wr = ram_wr_q & rdy;

  // per-cycle counter arithmetic and stall/finish decisions
  always_comb begin
    cnt_inc     = cnt + 3'd1;
    rcnt_inc    = rcnt + 3'd1;
    wr_stall    = is_io(addr) && io_buffer_full;
    rd_issue    = cnt < size;
    rd_cnt_nxt  = rd_issue ? cnt_inc : cnt;
    rd_rcnt_nxt = cap ? rcnt_inc : rcnt;
    // the last byte is still in flight when DONE is entered; DONE captures it
    rd_last     = (rd_cnt_nxt == size) && ((rd_rcnt_nxt + 3'd1) == size);
    data_merged = data;
    data_merged[{rcnt[1:0], 3'b000} +: 8] = in_ram_din;
  end

  // request acceptance, byte serialisation and completion sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      size         <= 3'd0;
      data         <= '0;
      cnt          <= 3'd0;
      rcnt         <= 3'd0;
      is_load      <= 1'b0;
      cap          <= 1'b0;
      ram_wr_q     <= 1'b0;
      out_rob_ce   <= 1'b0;
      out_rob_data <= '0;
      out_busy     <= 1'b0;
      out_ram_a    <= '0;
      out_ram_dout <= 8'd0;
    end else if (rdy) begin
      case (state)
        S_IDLE: begin
          out_rob_ce <= 1'b0;
          out_busy   <= 1'b0;
          ram_wr_q   <= 1'b0;
          if (in_rob_ce) begin
            addr     <= in_rob_addr;
            size     <= decode_size(in_rob_size);
            data     <= in_rob_data;
            is_load  <= 1'b0;
            out_busy <= 1'b1;
            rcnt     <= 3'd0;
            cap      <= 1'b0;
            // byte 0 goes out on the acceptance edge unless the IO buffer is full
            if (is_io(in_rob_addr) && io_buffer_full) begin
              cnt   <= 3'd0;
              state <= S_WRITE;
            end else begin
              out_ram_a    <= in_rob_addr;
              out_ram_dout <= in_rob_data[7:0];
              ram_wr_q     <= 1'b1;
              cnt          <= 3'd1;
              state        <= (decode_size(in_rob_size) == 3'd1) ? S_DONE : S_WRITE;
            end
          end else if (in_rob_load_ce) begin
            addr      <= in_rob_addr;
            size      <= decode_size(in_rob_size);
            data      <= '0;
            is_load   <= 1'b1;
            out_busy  <= 1'b1;
            out_ram_a <= in_rob_addr;
            cnt       <= 3'd1;
            rcnt      <= 3'd0;
            cap       <= 1'b0;
            state     <= S_READ;
          end
        end

        S_WRITE: begin
          if (wr_stall) begin
            ram_wr_q <= 1'b0;
          end else begin
            out_ram_a    <= addr + ADDR_WIDTH'(cnt);
            out_ram_dout <= byte_of(data, cnt);
            ram_wr_q     <= 1'b1;
            cnt          <= cnt_inc;
            if (cnt_inc == size) state <= S_DONE;
          end
        end

        S_READ: begin
          if (rd_issue) out_ram_a <= addr + ADDR_WIDTH'(cnt);
          if (cap) data[{rcnt[1:0], 3'b000} +: 8] <= in_ram_din;
          cnt  <= rd_cnt_nxt;
          rcnt <= rd_rcnt_nxt;
          // first address is only on the bus now; its byte arrives next cycle
          cap  <= 1'b1;
          if (rd_last) state <= S_DONE;
        end

        S_DONE: begin
          ram_wr_q   <= 1'b0;
          out_rob_ce <= 1'b1;
          cap        <= 1'b0;
          if (is_load) begin
            data         <= data_merged;
            out_rob_data <= data_merged;
            rcnt         <= rcnt_inc;
          end else begin
            out_rob_data <= '0;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_mem_responder.sv
// tb/tb_rob_mem_responder.sv - randomized self-checking bench for rob_mem_responder
module tb_rob_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        in_rob_ce;
  logic        in_rob_load_ce;
  logic [5:0]  in_rob_size;
  logic [31:0] in_rob_addr;
  logic [31:0] in_rob_data;
  logic        out_rob_ce;
  logic [31:0] out_rob_data;
  logic        out_busy;
  logic [31:0] out_ram_a;
  logic [7:0]  out_ram_dout;
  logic        out_ram_wr;
  logic [7:0]  in_ram_din;
  logic        io_buffer_full;

  int checks = 0;
  int failures = 0;

  // ram is what the DUT actually wrote; ref_mem is what it should have written
  logic [7:0] ram[logic [31:0]];
  logic [7:0] ref_mem[logic [31:0]];

  always #5 clk = ~clk;

  rob_mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_rob_ce(in_rob_ce), .in_rob_load_ce(in_rob_load_ce),
    .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr), .in_rob_data(in_rob_data),
    .out_rob_ce(out_rob_ce), .out_rob_data(out_rob_data), .out_busy(out_busy),
    .out_ram_a(out_ram_a), .out_ram_dout(out_ram_dout), .out_ram_wr(out_ram_wr),
    .in_ram_din(in_ram_din), .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
  endfunction

  // synchronous byte RAM that freezes with the rest of the system when rdy is low
  always @(posedge clk) begin
    if (out_ram_wr) ram[out_ram_a] = out_ram_dout;
    if (rdy) in_ram_din <= ram_rd(out_ram_a);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one request from the acceptance edge through the consumed completion cycle;
  // bit k of rdy_low / full_hi applies at edge k after the request (edge 0)
  task automatic run_txn(input bit ld, input bit both, input bit junk, input logic [5:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rdy_low, input logic [31:0] full_hi, input int exp_lat);
    int n, issued, stalls, eff, wr_seen, first_lat, eff_at_ce;
    bit io, done, busy_bad, wr_bad;
    logic [31:0] exp_data;
    n = (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
    io = (a[17:16] == 2'b11);
    issued = 0; stalls = 0; wr_seen = 0; first_lat = -1; eff_at_ce = -1;
    done = 0; busy_bad = 0; wr_bad = 0;
    exp_data = '0;
    if (ld) for (int i = 0; i < n; i++) exp_data[8*i +: 8] = ref_rd(a + 32'(i));
    in_rob_ce = !ld;
    in_rob_load_ce = ld || both;
    in_rob_size = sz;
    in_rob_addr = a;
    in_rob_data = d;
    rdy = 1'b1;
    io_buffer_full = full_hi[0];
    eff = 1;
    if (!ld) begin
      if (io && full_hi[0]) stalls++;
      else issued++;
    end
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      if (!out_busy) busy_bad = 1;
      if (out_ram_wr) begin
        if (ld || wr_seen >= n || out_ram_a !== a + 32'(wr_seen) || out_ram_dout !== d[8*(wr_seen%4) +: 8])
          wr_bad = 1;
        wr_seen++;
      end
      if (out_rob_ce && first_lat < 0) begin
        first_lat = cyc;
        eff_at_ce = eff;
      end
      if (out_rob_ce && rdy) done = 1;
      if (!done) begin
        if (cyc == 1) begin
          in_rob_ce = junk;
          in_rob_load_ce = 1'b0;
          in_rob_addr = a ^ 32'h40;
          in_rob_data = ~d;
          in_rob_size = 6'd4;
        end else begin
          in_rob_ce = 1'b0;
        end
        rdy = (cyc < 32) ? !rdy_low[cyc] : 1'b1;
        io_buffer_full = (cyc < 32) ? full_hi[cyc] : 1'b0;
        if (rdy) begin
          eff++;
          if (!ld && issued < n) begin
            if (io && io_buffer_full) stalls++;
            else issued++;
          end
        end
      end
    end
    check_eq("complete", 64'(done), 64'd1);
    check_eq("ce_edges", 64'(eff_at_ce), ld ? 64'(n + 2) : 64'(n + 1 + stalls));
    if (exp_lat >= 0) check_eq("latency", 64'(first_lat), 64'(exp_lat));
    check_eq("write_count", 64'(wr_seen), ld ? 64'd0 : 64'(n));
    check_eq("write_bytes", 64'(wr_bad), 64'd0);
    check_eq("busy", 64'(busy_bad), 64'd0);
    check_eq("rob_data", 64'(out_rob_data), 64'(exp_data));
    if (!ld) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    io_buffer_full = 1'b0;
  endtask

  initial begin
    logic [5:0] sizes[7];
    int bad;
    bit ld;
    logic [31:0] a;
    sizes = '{6'd1, 6'd2, 6'd4, 6'd0, 6'd3, 6'd7, 6'd63};
    rst = 1'b1; rdy = 1'b1; in_rob_ce = 1'b0; in_rob_load_ce = 1'b0;
    in_rob_size = 6'd0; in_rob_addr = '0; in_rob_data = '0; io_buffer_full = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctl", {out_rob_ce, out_busy, out_ram_wr, out_ram_dout, out_rob_data}, 64'd0);
    check_eq("reset_addr", 64'(out_ram_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // store word, little-endian, completion in cycle 5
    run_txn(0, 0, 0, 6'd4, 32'h100, 32'hDEADBEEF, 32'd0, 32'd0, 5);
    // IO load of a halfword returning 0x34, 0x12
    ram[32'h30000] = 8'h34; ram[32'h30001] = 8'h12;
    ref_mem[32'h30000] = 8'h34; ref_mem[32'h30001] = 8'h12;
    run_txn(1, 0, 0, 6'd2, 32'h30000, 32'd0, 32'd0, 32'd0, 4);
    // IO store held off by a full buffer for three cycles
    run_txn(0, 0, 0, 6'd1, 32'h30000, 32'h41, 32'd0, 32'h7, 5);
    // store and load together, plus a second store while busy
    run_txn(0, 1, 1, 6'd4, 32'h180, 32'hCAFEF00D, 32'd0, 32'd0, 5);
    // rdy low for two cycles mid-store
    run_txn(0, 0, 0, 6'd4, 32'h1C0, 32'h01234567, 32'hC, 32'd0, 7);
    // read back what the directed stores left behind
    run_txn(1, 0, 0, 6'd4, 32'h180, 32'd0, 32'd0, 32'd0, 6);

    // reset in the middle of a 4-byte load
    in_rob_load_ce = 1'b1; in_rob_size = 6'd4; in_rob_addr = 32'h200;
    @(negedge clk);
    in_rob_load_ce = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ctl", {out_rob_ce, out_busy, out_ram_wr, out_ram_dout, out_rob_data}, 64'd0);
    check_eq("midrst_addr", 64'(out_ram_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_rob_ce || out_busy) bad++;
    end
    check_eq("after_rst_quiet", 64'(bad), 64'd0);
    run_txn(0, 0, 0, 6'd2, 32'h204, 32'h0000BEEF, 32'd0, 32'd0, 3);

    // random traffic including wrap-around and IO stalls
    for (int t = 0; t < 40; t++) begin
      ld = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: a = 32'hFFFF_FFFE;
        1, 2: a = 32'h30000 + 32'($urandom_range(0, 12));
        default: a = 32'h100 + 32'($urandom_range(0, 12));
      endcase
      run_txn(ld, !ld && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              sizes[$urandom_range(0, 6)], a, $urandom,
              $urandom & $urandom & $urandom & 32'hFFFF_FFFE, $urandom & $urandom, -1);
    end

    in_rob_ce = 1'b0; in_rob_load_ce = 1'b0; rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("final_idle", {62'd0, out_rob_ce, out_busy}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
